// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully connected layer blocks:
// controller state encoding, default accumulator width and int8 saturation.
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    REQUANT,
    WRITE,
    DONE
  } fc_state_e;

  localparam int FC_ACC_W = 32;

  function automatic logic signed [7:0] sat8(input logic signed [63:0] x);
    if (x > 64'sd127) begin
      return 8'sd127;
    end else if (x < -64'sd128) begin
      return -8'sd128;
    end else begin
      return x[7:0];
    end
  endfunction

endpackage

// File: rtl/fc1_layer_if.sv
// Handshake and memory-port bundle of the fc1_layer block; the master side is
// the layer itself, the slave side is the sequencer plus the RAM/ROM models.
interface fc1_layer_if #(
  parameter int WADDR_W = 17
);

  logic                     start_FC1;
  logic                     end_FC1;
  logic [15:0]              ram_addr_r;
  logic                     ram_en_r;
  logic signed [7:0]        ram_data_r;
  logic [WADDR_W-1:0]       w_addr;
  logic                     w_en;
  logic signed [7:0]        w_data;
  logic [7:0]               b_addr;
  logic signed [31:0]       b_data;
  logic [15:0]              ram_addr_w;
  logic signed [7:0]        ram_data_w;
  logic                     ram_en;
  logic                     ram_wea;

  modport master (
    input  start_FC1, ram_data_r, w_data, b_data,
    output end_FC1, ram_addr_r, ram_en_r, w_addr, w_en, b_addr,
           ram_addr_w, ram_data_w, ram_en, ram_wea
  );

  modport slave (
    output start_FC1, ram_data_r, w_data, b_data,
    input  end_FC1, ram_addr_r, ram_en_r, w_addr, w_en, b_addr,
           ram_addr_w, ram_data_w, ram_en, ram_wea
  );

endinterface

// File: rtl/fc_mac.sv
// Multiply-accumulate and requantisation datapath of the fully connected layer.
// Define FC1_RELU_EN to clamp negative results to zero (hidden layers).
module fc_mac
  import fc_pkg::*;
#(
  parameter int ACC_W  = FC_ACC_W,
  parameter int SHIFT  = 8,
  parameter int RD_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               issue_i,
  input  logic               bias_issue_i,
  input  logic signed [7:0]  act_i,
  input  logic signed [7:0]  wgt_i,
  input  logic signed [31:0] bias_i,
  output logic signed [7:0]  res_o
);

  localparam int SUM_W = ACC_W + 1;

  logic [RD_LAT-1:0]        vld_q;
  logic [RD_LAT-1:0]        bvld_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [31:0]       bias_q;
  logic signed [15:0]       prod;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  shifted;
  logic signed [7:0]        sat;

  assign prod = act_i * wgt_i;

  // Valid tags travel alongside the memory read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      bvld_q <= '0;
      acc_q  <= '0;
      bias_q <= '0;
    end else begin
      vld_q  <= (vld_q << 1) | RD_LAT'(issue_i);
      bvld_q <= (bvld_q << 1) | RD_LAT'(bias_issue_i);
      if (clr_i) begin
        acc_q <= '0;
      end else if (vld_q[RD_LAT-1]) begin
        acc_q <= acc_q + {{(ACC_W-16){prod[15]}}, prod};
      end
      if (bvld_q[RD_LAT-1]) begin
        bias_q <= bias_i;
      end
    end
  end

  // One guard bit keeps acc + bias from wrapping before the floor shift
  assign sum     = {acc_q[ACC_W-1], acc_q} + {{(SUM_W-32){bias_q[31]}}, bias_q};
  assign shifted = sum >>> SHIFT;
  assign sat     = sat8({{(64-SUM_W){shifted[SUM_W-1]}}, shifted});

`ifdef FC1_RELU_EN
  assign res_o = sat[7] ? 8'sd0 : sat;
`else
  assign res_o = sat;
`endif

endmodule

// File: rtl/fc1_layer.sv
// FC1 controller: walks OUT_LEN neurons over an IN_LEN activation vector,
// generating RAM/ROM addresses and writing one requantised int8 per neuron.
module fc1_layer
  import fc_pkg::*;
#(
  parameter int          IN_LEN     = 1600,
  parameter int          OUT_LEN    = 64,
  parameter logic [15:0] IFMAP_BASE = 16'd0,
  parameter logic [15:0] OFMAP_BASE = 16'd1600,
  parameter int          WADDR_W    = 17,
  parameter int          RD_LAT     = 2,
  parameter int          SHIFT      = 8,
  parameter int          ACC_W      = FC_ACC_W
) (
  input  logic        clk,
  input  logic        rst_n,
  fc1_layer_if.master bus
);

  localparam int K_W = $clog2(IN_LEN + 1);
  localparam int D_W = $clog2(RD_LAT + 1);

  fc_state_e           state_q;
  logic [K_W-1:0]      k_q;
  logic [7:0]          n_q;
  logic [D_W-1:0]      dcnt_q;
  logic [15:0]         rd_addr_q;
  logic [WADDR_W-1:0]  w_addr_q;
  logic [7:0]          b_addr_q;
  logic                rd_en_q;
  logic [15:0]         wr_addr_q;
  logic signed [7:0]   wr_data_q;
  logic                wr_en_q;
  logic                end_q;

  logic                last_k;
  logic                last_n;
  logic                acc_clr;
  logic signed [7:0]   res;

  assign last_k  = (k_q == K_W'(IN_LEN - 1));
  assign last_n  = (n_q == 8'(OUT_LEN - 1));
  assign acc_clr = ((state_q == IDLE) && bus.start_FC1) || ((state_q == WRITE) && !last_n);

  fc_mac #(
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT),
    .RD_LAT (RD_LAT)
  ) u_mac (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (acc_clr),
    .issue_i      (rd_en_q),
    .bias_issue_i (rd_en_q && (k_q == '0)),
    .act_i        (bus.ram_data_r),
    .wgt_i        (bus.w_data),
    .bias_i       (bus.b_data),
    .res_o        (res)
  );

  // Weight address runs on across neurons, so it is never reloaded mid-pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      n_q       <= '0;
      dcnt_q    <= '0;
      rd_addr_q <= '0;
      w_addr_q  <= '0;
      b_addr_q  <= '0;
      rd_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      end_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_FC1) begin
            state_q   <= ISSUE;
            n_q       <= '0;
            k_q       <= '0;
            rd_addr_q <= IFMAP_BASE;
            w_addr_q  <= '0;
            b_addr_q  <= '0;
            rd_en_q   <= 1'b1;
          end
        end
        ISSUE: begin
          k_q       <= k_q + K_W'(1);
          rd_addr_q <= rd_addr_q + 16'd1;
          w_addr_q  <= w_addr_q + WADDR_W'(1);
          if (last_k) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            dcnt_q  <= '0;
          end
        end
        DRAIN: begin
          if (dcnt_q == D_W'(RD_LAT - 1)) begin
            state_q <= REQUANT;
          end else begin
            dcnt_q <= dcnt_q + D_W'(1);
          end
        end
        REQUANT: begin
          state_q   <= WRITE;
          wr_data_q <= res;
          wr_addr_q <= OFMAP_BASE + {8'd0, n_q};
          wr_en_q   <= 1'b1;
        end
        WRITE: begin
          if (last_n) begin
            state_q <= DONE;
            end_q   <= 1'b1;
          end else begin
            state_q   <= ISSUE;
            n_q       <= n_q + 8'd1;
            k_q       <= '0;
            rd_addr_q <= IFMAP_BASE;
            b_addr_q  <= n_q + 8'd1;
            rd_en_q   <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.end_FC1    = end_q;
  assign bus.ram_addr_r = rd_addr_q;
  assign bus.ram_en_r   = rd_en_q;
  assign bus.w_addr     = w_addr_q;
  assign bus.w_en       = rd_en_q;
  assign bus.b_addr     = b_addr_q;
  assign bus.ram_addr_w = wr_addr_q;
  assign bus.ram_data_w = wr_data_q;
  assign bus.ram_en     = wr_en_q;
  assign bus.ram_wea    = wr_en_q;

endmodule

// File: tb/tb_fc1_layer.sv
// Directed bench for fc1_layer: two small instances (4x2 with SHIFT=0 and
// 16x2 with SHIFT=8) backed by 2-cycle-latency RAM/ROM models.
module tb_fc1_layer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

`ifdef FC1_RELU_EN
  localparam logic signed [7:0] SAT_NEG = 8'sd0;
  localparam logic signed [7:0] NEG_ONE = 8'sd0;
`else
  localparam logic signed [7:0] SAT_NEG = -8'sd128;
  localparam logic signed [7:0] NEG_ONE = -8'sd1;
`endif

  fc1_layer_if #(.WADDR_W(3)) bus0 ();
  fc1_layer_if #(.WADDR_W(5)) bus1 ();

  fc1_layer #(.IN_LEN(4), .OUT_LEN(2), .IFMAP_BASE(16'd0), .OFMAP_BASE(16'd1600),
              .WADDR_W(3), .RD_LAT(2), .SHIFT(0), .ACC_W(32))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  fc1_layer #(.IN_LEN(16), .OUT_LEN(2), .IFMAP_BASE(16'd32), .OFMAP_BASE(16'd200),
              .WADDR_W(5), .RD_LAT(2), .SHIFT(8), .ACC_W(32))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic signed [7:0]  act0 [4];
  logic signed [7:0]  wt0  [8];
  logic signed [31:0] bias0[2];
  logic signed [7:0]  act1 [16];
  logic signed [7:0]  wt1  [32];
  logic signed [31:0] bias1[2];
  logic signed [7:0]  a0_s, w0_s, a1_s, w1_s;
  logic signed [31:0] b0_s, b1_s;

  // Two-stage read pipelines; unenabled reads return a poison value
  always @(posedge clk) begin
    a0_s <= bus0.ram_en_r ? act0[bus0.ram_addr_r[1:0]] : 8'sh5a;
    w0_s <= bus0.w_en ? wt0[bus0.w_addr] : 8'sh5a;
    b0_s <= bias0[bus0.b_addr[0]];
    bus0.ram_data_r <= a0_s;
    bus0.w_data     <= w0_s;
    bus0.b_data     <= b0_s;
    a1_s <= bus1.ram_en_r ? act1[bus1.ram_addr_r[3:0]] : 8'sh5a;
    w1_s <= bus1.w_en ? wt1[bus1.w_addr] : 8'sh5a;
    b1_s <= bias1[bus1.b_addr[0]];
    bus1.ram_data_r <= a1_s;
    bus1.w_data     <= w1_s;
    bus1.b_data     <= b1_s;
  end

  logic [15:0]       rd_log[$];
  logic [2:0]        wl_log[$];
  logic [7:0]        b_log[$];
  logic [15:0]       wa0[$], wa1[$];
  logic signed [7:0] wd0[$], wd1[$];
  int                ends0 = 0;
  int                en_mis = 0;
  logic              en_prev = 1'b0;

  always @(negedge clk) begin
    if (bus0.ram_en_r) begin
      rd_log.push_back(bus0.ram_addr_r);
      wl_log.push_back(bus0.w_addr);
      if (!en_prev) b_log.push_back(bus0.b_addr);
    end
    if (bus0.w_en !== bus0.ram_en_r) en_mis <= en_mis + 1;
    en_prev <= bus0.ram_en_r;
    if (bus0.ram_en && bus0.ram_wea) begin
      wa0.push_back(bus0.ram_addr_w);
      wd0.push_back(bus0.ram_data_w);
    end
    if (bus0.end_FC1) ends0 <= ends0 + 1;
    if (bus1.ram_en && bus1.ram_wea) begin
      wa1.push_back(bus1.ram_addr_w);
      wd1.push_back(bus1.ram_data_w);
    end
  end

  task automatic load_basic();
    act0  = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    for (int i = 0; i < 8; i++) wt0[i] = 8'sd1;
    bias0 = '{32'sd0, -32'sd5};
  endtask

  task automatic run_pass(input bit sel, output int cyc);
    cyc = 0;
    if (sel) bus1.start_FC1 = 1'b1;
    else     bus0.start_FC1 = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      bus0.start_FC1 = 1'b0;
      bus1.start_FC1 = 1'b0;
    end while (!(sel ? bus1.end_FC1 : bus0.end_FC1) && cyc < 300);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.start_FC1 = 1'b0;
    bus1.start_FC1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus0.end_FC1, bus0.ram_en_r, bus0.w_en, bus0.ram_en, bus0.ram_wea} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl0: got %b expected 00000",
               {bus0.end_FC1, bus0.ram_en_r, bus0.w_en, bus0.ram_en, bus0.ram_wea});
    end
    checks++;
    if (bus0.ram_addr_r !== 16'd0 || bus0.w_addr !== 3'd0 || bus0.b_addr !== 8'd0 ||
        bus0.ram_addr_w !== 16'd0 || bus0.ram_data_w !== 8'sd0) begin
      errors++;
      $display("FAIL reset_bus0: addr_r=%0d w=%0d b=%0d addr_w=%0d data_w=%0d expected all 0",
               bus0.ram_addr_r, bus0.w_addr, bus0.b_addr, bus0.ram_addr_w, bus0.ram_data_w);
    end
    checks++;
    if ({bus1.end_FC1, bus1.ram_en_r, bus1.ram_en, bus1.ram_addr_w, bus1.ram_data_w} !== 27'b0) begin
      errors++;
      $display("FAIL reset_bus1: got %h expected 0",
               {bus1.end_FC1, bus1.ram_en_r, bus1.ram_en, bus1.ram_addr_w, bus1.ram_data_w});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc, rb, bb, ab;
    load_basic();
    rb = rd_log.size(); bb = b_log.size(); ab = wa0.size();
    run_pass(1'b0, cyc);
    checks++;
    if (cyc !== 17) begin
      errors++; $display("FAIL basic_latency: got %0d cycles, expected 17", cyc);
    end
    @(negedge clk);
    checks++;
    if (bus0.end_FC1 !== 1'b0) begin
      errors++; $display("FAIL end_pulse_width: end_FC1=%b, expected 0", bus0.end_FC1);
    end
    checks++;
    if (wa0.size() - ab !== 2) begin
      errors++; $display("FAIL basic_wr_count: got %0d expected 2", wa0.size() - ab);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wa0[ab+i] !== 16'(1600 + i) || wd0[ab+i] !== ((i == 0) ? 8'sd10 : 8'sd5)) begin
          errors++;
          $display("FAIL basic_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                   i, wa0[ab+i], wd0[ab+i], 1600 + i, (i == 0) ? 10 : 5);
        end
      end
    end
    checks++;
    if (rd_log.size() - rb !== 8) begin
      errors++; $display("FAIL issue_cycles: got %0d expected 8", rd_log.size() - rb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rd_log[rb+i] !== 16'(i % 4) || wl_log[rb+i] !== 3'(i)) begin
          errors++;
          $display("FAIL addr_seq%0d: got ram_addr_r %0d w_addr %0d expected %0d %0d",
                   i, rd_log[rb+i], wl_log[rb+i], i % 4, i);
        end
      end
    end
    checks++;
    if (b_log.size() - bb !== 2 || b_log[bb] !== 8'd0 || b_log[bb+1] !== 8'd1) begin
      errors++; $display("FAIL bias_addr_seq: got %0d entries, expected b_addr 0 then 1", b_log.size() - bb);
    end
  endtask

  task automatic test_saturation();
    int cyc, ab;
    for (int i = 0; i < 16; i++) act1[i] = 8'sd127;
    for (int i = 0; i < 32; i++) wt1[i] = (i < 16) ? 8'sd127 : -8'sd128;
    bias1 = '{32'sd0, 32'sd0};
    ab = wa1.size();
    run_pass(1'b1, cyc);
    @(negedge clk);
    checks++;
    if (cyc !== 41) begin
      errors++; $display("FAIL sat_latency: got %0d cycles, expected 41", cyc);
    end
    checks++;
    if (wa1.size() - ab !== 2) begin
      errors++; $display("FAIL sat_wr_count: got %0d expected 2", wa1.size() - ab);
    end else begin
      checks++;
      if (wa1[ab] !== 16'd200 || wd1[ab] !== 8'sd127) begin
        errors++; $display("FAIL sat_pos: got addr %0d data %0d expected 200 127", wa1[ab], wd1[ab]);
      end
      checks++;
      if (wa1[ab+1] !== 16'd201 || wd1[ab+1] !== SAT_NEG) begin
        errors++; $display("FAIL sat_neg: got addr %0d data %0d expected 201 %0d", wa1[ab+1], wd1[ab+1], SAT_NEG);
      end
    end
  endtask

  task automatic test_floor();
    int cyc, ab;
    for (int i = 0; i < 16; i++) act1[i] = (i == 0) ? 8'sd1 : 8'sd0;
    for (int i = 0; i < 32; i++) wt1[i] = 8'sd0;
    wt1[0]  = -8'sd1;
    wt1[16] = 8'sd1;
    bias1 = '{32'sd0, 32'sd510};
    ab = wa1.size();
    run_pass(1'b1, cyc);
    @(negedge clk);
    checks++;
    if (wa1.size() - ab !== 2) begin
      errors++; $display("FAIL floor_wr_count: got %0d expected 2", wa1.size() - ab);
    end else begin
      checks++;
      if (wd1[ab] !== NEG_ONE) begin
        errors++; $display("FAIL floor_minus1: got %0d expected %0d", wd1[ab], NEG_ONE);
      end
      checks++;
      if (wd1[ab+1] !== 8'sd1) begin
        errors++; $display("FAIL bias_shift_511: got %0d expected 1", wd1[ab+1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, ab;
    load_basic();
    ab = wa0.size();
    bus0.start_FC1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus0.start_FC1 = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus0.end_FC1, bus0.ram_en_r, bus0.w_en, bus0.ram_en, bus0.ram_wea} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: got %b expected 00000",
               {bus0.end_FC1, bus0.ram_en_r, bus0.w_en, bus0.ram_en, bus0.ram_wea});
    end
    checks++;
    if (bus0.ram_addr_r !== 16'd0 || bus0.w_addr !== 3'd0 || bus0.b_addr !== 8'd0 ||
        bus0.ram_addr_w !== 16'd0 || bus0.ram_data_w !== 8'sd0) begin
      errors++;
      $display("FAIL midreset_bus: addr_r=%0d w=%0d b=%0d addr_w=%0d data_w=%0d expected all 0",
               bus0.ram_addr_r, bus0.w_addr, bus0.b_addr, bus0.ram_addr_w, bus0.ram_data_w);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wa0.size() - ab !== 1) begin
      errors++; $display("FAIL midreset_writes: got %0d expected 1", wa0.size() - ab);
    end
    rst_n = 1'b1;
    @(negedge clk);
    ab = wa0.size();
    run_pass(1'b0, cyc);
    @(negedge clk);
    checks++;
    if (cyc !== 17 || wa0.size() - ab !== 2) begin
      errors++; $display("FAIL rerun_shape: got %0d cycles %0d writes expected 17 2", cyc, wa0.size() - ab);
    end else begin
      checks++;
      if (wd0[ab] !== 8'sd10 || wd0[ab+1] !== 8'sd5) begin
        errors++; $display("FAIL rerun_data: got %0d %0d expected 10 5", wd0[ab], wd0[ab+1]);
      end
    end
  endtask

  task automatic test_start_in_drain();
    int cyc, ab, eb, rb;
    load_basic();
    ab = wa0.size(); eb = ends0; rb = rd_log.size();
    bus0.start_FC1 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus0.start_FC1 = (cyc == 5 || cyc == 13);
    end while (!bus0.end_FC1 && cyc < 300);
    bus0.start_FC1 = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (cyc !== 17) begin
      errors++; $display("FAIL drain_latency: got %0d cycles, expected 17", cyc);
    end
    checks++;
    if (wa0.size() - ab !== 2 || ends0 - eb !== 1 || rd_log.size() - rb !== 8) begin
      errors++;
      $display("FAIL drain_start_ignored: got %0d writes %0d ends %0d reads expected 2 1 8",
               wa0.size() - ab, ends0 - eb, rd_log.size() - rb);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, ab, eb;
    load_basic();
    ab = wa0.size(); eb = ends0;
    bus0.start_FC1 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
    end while (!bus0.end_FC1 && cyc < 300);
    checks++;
    if (cyc !== 17) begin
      errors++; $display("FAIL b2b_first_end: got %0d cycles, expected 17", cyc);
    end
    repeat (2) @(negedge clk);
    cyc += 2;
    bus0.start_FC1 = 1'b0;
    while (!bus0.end_FC1 && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (cyc !== 35) begin
      errors++; $display("FAIL b2b_second_end: got %0d cycles, expected 35", cyc);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (wa0.size() - ab !== 4 || ends0 - eb !== 2) begin
      errors++; $display("FAIL b2b_counts: got %0d writes %0d ends expected 4 2", wa0.size() - ab, ends0 - eb);
    end else begin
      checks++;
      if (wd0[ab+2] !== 8'sd10 || wd0[ab+3] !== 8'sd5 || wa0[ab+3] !== 16'd1601) begin
        errors++;
        $display("FAIL b2b_second_data: got %0d %0d @%0d expected 10 5 @1601", wd0[ab+2], wd0[ab+3], wa0[ab+3]);
      end
    end
    checks++;
    if (en_mis !== 0) begin
      errors++; $display("FAIL w_en_tracks_ram_en_r: got %0d mismatched cycles expected 0", en_mis);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_floor();
    test_reset_mid();
    test_start_in_drain();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc1_layer.md
# fc1_layer

Fully connected stage directly downstream of the second max-pooling stage. It consumes the flattened int8 activation vector that stage writes to activation RAM, and computes OUT_LEN dot products against an int8 weight ROM plus an int32 bias ROM. Each result is requantised to int8, optionally passed through ReLU, and written back to activation RAM. Control uses the same start/end pulse handshake as the other layer blocks.

## Interface
- IN_LEN, 1600: input vector length (10×10×16 flattened pooling output).
- OUT_LEN, 64: number of output neurons.
- IFMAP_BASE, 16'd0: activation RAM address of input element 0.
- OFMAP_BASE, 16'd1600: activation RAM address of output neuron 0.
- WADDR_W, 17: weight ROM address width; must satisfy 2^WADDR_W ≥ IN_LEN·OUT_LEN.
- RD_LAT, 2: read latency in cycles of the RAM, weight ROM and bias ROM (all identical).
- SHIFT, 8: arithmetic right shift applied to the accumulator before saturation.
- ACC_W, 32: accumulator width.

Ports:
- clk  in  1  rising-edge clock; the whole block uses it.
- rst_n  in  1  asynchronous, active-low reset.
- start_FC1  in  1  start request; sampled only in IDLE.
- end_FC1  out  1  one-cycle completion pulse.
- ram_addr_r  out  16  activation RAM read address.
- ram_en_r  out  1  activation RAM read enable.
- ram_data_r  in  8  signed activation, valid RD_LAT cycles after the read is issued.
- w_addr  out  WADDR_W  weight ROM address, equal to n·IN_LEN + k.
- w_en  out  1  weight ROM enable.
- w_data  in  8  signed weight.
- b_addr  out  8  bias ROM address, equal to n.
- b_data  in  32  signed bias.
- ram_addr_w  out  16  activation RAM write address.
- ram_data_w  out  8  signed output value.
- ram_en  out  1  write port enable.
- ram_wea  out  1  write enable.

## Operation
- States and transitions:
  - IDLE: go to ISSUE when start_FC1 = 1; set n = 0, k = 0.
  - ISSUE: each cycle, issue reads at ram_addr_r = IFMAP_BASE + k and w_addr = n·IN_LEN + k, then increment k. When k = 0, also issue the bias read at b_addr = n. After k = IN_LEN−1, go to DRAIN.
  - DRAIN: stay RD_LAT cycles while the last products return, then go to REQUANT.
  - REQUANT: compute r = sat8((acc + bias) >>> SHIFT), then go to WRITE.
  - WRITE: assert ram_en = ram_wea = 1, ram_addr_w = OFMAP_BASE + n, ram_data_w = r. If n = OUT_LEN−1, go to DONE; otherwise increment n, clear the accumulator and go to ISSUE.
  - DONE: end_FC1 = 1 for this cycle only, then go to IDLE.
- MAC datapath:
  - A read-valid shift register of depth RD_LAT tags the returning data.
  - acc += sext(ram_data_r × w_data), a 16-bit signed product accumulated at ACC_W.
  - The accumulator clears on entry to ISSUE.
  - Bias is captured when its valid tag returns.
- Arithmetic:
  - The shift is arithmetic and rounds toward −∞; there is no rounding term.
  - sat8 clamps to the range −128 to 127.
  - At the default sizes the accumulator cannot overflow (|sum| ≤ 1600·16384 < 2^31).
- Boundary conditions:
  - start_FC1 outside IDLE is ignored.
  - start_FC1 held high through DONE starts a new pass on the following IDLE cycle.
  - rst_n low at any time forces IDLE immediately and clears the accumulator, n, k and all valid tags.
  - A write in flight during reset does not occur.

## Timing
- Reset values: all outputs 0.
- Per-neuron latency is IN_LEN + RD_LAT + 2 cycles.
- Total latency from the start sample to end_FC1 is 1 + OUT_LEN·(IN_LEN + RD_LAT + 2) cycles; at the defaults this is 102,657 cycles.
- ram_en_r and w_en are high exactly during ISSUE cycles.
- ram_en and ram_wea are high exactly one cycle per neuron.
- There is no backpressure.

## Configuration
- FC1_RELU_EN defined: the REQUANT stage outputs max(r, 0), so negative results are written as 0.
- FC1_RELU_EN undefined: the signed saturated r is written unchanged. Use this for the final logits layer.

## Structure
- Package fc_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, REQUANT, WRITE, DONE);
  - the ACC_W default;
  - the sat8 function.
- Sub-module fc_mac holds:
  - the signed 8×8 multiplier;
  - the ACC_W accumulator with clear and valid inputs;
  - the bias add, shift and saturation, with the ReLU gated by the macro.
- The top module holds the FSM, the counters and the address generation.

## Test plan
- IN_LEN=4, OUT_LEN=2, SHIFT=0, activations {1,2,3,4}, all weights 1, biases {0,−5} → writes 10 then 5 to OFMAP_BASE and OFMAP_BASE+1; end_FC1 pulses at cycle 1 + 2·(4+2+2) = 17.
- Activations all 127, weights all 127, IN_LEN=16, SHIFT=8 → acc = 258064, which shifts to 1008 and saturates to 127. Weights all −128 → the written value is −128 without FC1_RELU_EN and 0 with it.
- Sum = −1 with SHIFT=1 → written value −1, confirming floor rounding.
- Assert rst_n mid-ISSUE for neuron 1 → all outputs go to 0 asynchronously and no write occurs. A new start afterwards reproduces the full correct result set.
- Pulse start_FC1 during DRAIN → ignored; the number of writes equals OUT_LEN exactly.
- Check the address sequence: w_addr runs contiguously over 0..IN_LEN·OUT_LEN−1, ram_addr_r wraps back to IFMAP_BASE for each neuron, and b_addr steps 0..OUT_LEN−1.
